// File: rtl/uart_host_tx_pkg.sv
// Shared definitions for the host-side UART transmitter: FSM states, parity
// modes and bit-period arithmetic.
package uart_host_tx_pkg;

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    START = 3'd1,
    DATA  = 3'd2,
    PAR   = 3'd3,
    STOP  = 3'd4
  } tx_state_t;

  localparam int PARITY_NONE = 0;
  localparam int PARITY_EVEN = 1;
  localparam int PARITY_ODD  = 2;

  function automatic int clks_per_bit(input int clk_freq, input int baud_rate);
    return clk_freq / baud_rate;
  endfunction

  // acc is the XOR of all data bits
  function automatic logic parity_bit(input int mode, input logic acc);
    case (mode)
      PARITY_EVEN: return acc;
      PARITY_ODD:  return ~acc;
      default:     return 1'b1;
    endcase
  endfunction

endpackage

// File: rtl/uart_host_tx_fifo.sv
// Synchronous byte FIFO with count, full/empty and first-word-fall-through read.
// Writes are refused when full regardless of a same-cycle pop.
module uart_host_tx_fifo #(
  parameter int DEPTH_LOG2 = 4
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  push,
  input  logic [7:0]            wdata,
  input  logic                  pop,
  output logic [7:0]            rdata,
  output logic                  full,
  output logic                  empty,
  output logic [DEPTH_LOG2:0]   count
);

  localparam int DEPTH = 2 ** DEPTH_LOG2;
  localparam logic [DEPTH_LOG2:0] FULL_CNT = (DEPTH_LOG2 + 1)'(DEPTH);

  logic [7:0]            mem [DEPTH];
  logic [DEPTH_LOG2-1:0] wptr;
  logic [DEPTH_LOG2-1:0] rptr;
  logic                  do_push;
  logic                  do_pop;

  assign full    = (count == FULL_CNT);
  assign empty   = (count == '0);
  assign do_push = push && !full;
  assign do_pop  = pop && !empty;
  assign rdata   = mem[rptr];

  always_ff @(posedge clk) begin
    if (do_push) mem[wptr] <= wdata;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wptr  <= '0;
      rptr  <= '0;
      count <= '0;
    end else begin
      if (do_push) wptr <= wptr + 1'b1;
      if (do_pop)  rptr <= rptr + 1'b1;
      case ({do_push, do_pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

endmodule

// File: rtl/uart_host_tx.sv
// Host-side UART transmitter: FIFO-buffered bytes serialised LSB-first with
// optional parity and 1 or 2 stop bits onto an idle-high line.
//
//   state | meaning
//   IDLE  | line high, waiting for a queued byte (one arming cycle before launch)
//   START | start bit (low) for one bit period
//   DATA  | data bits 0..7, LSB first
//   PAR   | parity bit (PARITY != 0 only)
//   STOP  | stop bit(s) high; back-to-back launch if FIFO non-empty
module uart_host_tx
  import uart_host_tx_pkg::*;
#(
  parameter int CLK_FREQ        = 100_000_000,
  parameter int BAUD_RATE       = 115_200,
  parameter int FIFO_DEPTH_LOG2 = 4,
  parameter int PARITY          = 0,
  parameter int STOP_BITS       = 1
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       in_valid,
  input  logic [7:0]                 in_data,
  output logic                       in_ready,
  output logic                       tx,
  output logic                       busy,
  output logic [FIFO_DEPTH_LOG2:0]   fifo_count
);

  localparam int CPB = clks_per_bit(CLK_FREQ, BAUD_RATE);
  localparam int CW  = $clog2(CPB);

  tx_state_t     state;
  logic [CW-1:0] baud_cnt;
  logic [2:0]    bit_idx;
  logic [2:0]    next_idx;
  logic [7:0]    shifter;
  logic          par_acc;
  logic          arm;
  logic [7:0]    rdata;
  logic          full;
  logic          empty;
  logic          bit_end;
  logic          stop_done;
  logic          launch;

  uart_host_tx_fifo #(
    .DEPTH_LOG2(FIFO_DEPTH_LOG2)
  ) u_fifo (
    .clk   (clk),
    .rst   (rst),
    .push  (in_valid),
    .wdata (in_data),
    .pop   (launch),
    .rdata (rdata),
    .full  (full),
    .empty (empty),
    .count (fifo_count)
  );

  assign in_ready  = !full;
  assign busy      = (state != IDLE) || (fifo_count != '0);
  assign bit_end   = (baud_cnt == CW'(CPB - 1));
  assign next_idx  = bit_idx + 3'd1;
  assign stop_done = (state == STOP) && bit_end && (bit_idx == 3'(STOP_BITS - 1));
  assign launch    = !empty && (((state == IDLE) && arm) || stop_done);

  always_ff @(posedge clk) begin
    if (rst) begin
      state    <= IDLE;
      baud_cnt <= '0;
      bit_idx  <= '0;
      shifter  <= '0;
      par_acc  <= 1'b0;
      arm      <= 1'b0;
      tx       <= 1'b1;
    end else begin
      baud_cnt <= bit_end ? '0 : baud_cnt + 1'b1;
      case (state)
        IDLE: begin
          baud_cnt <= '0;
          arm      <= !empty;
          if (launch) begin
            state   <= START;
            shifter <= rdata;
            tx      <= 1'b0;
            arm     <= 1'b0;
          end
        end
        START: if (bit_end) begin
          state   <= DATA;
          bit_idx <= '0;
          tx      <= shifter[0];
          par_acc <= shifter[0];
        end
        DATA: if (bit_end) begin
          if (bit_idx == 3'd7) begin
            bit_idx <= '0;
            if (PARITY == PARITY_NONE) begin
              state <= STOP;
              tx    <= 1'b1;
            end else begin
              state <= PAR;
              tx    <= parity_bit(PARITY, par_acc);
            end
          end else begin
            bit_idx <= next_idx;
            tx      <= shifter[next_idx];
            par_acc <= par_acc ^ shifter[next_idx];
          end
        end
        PAR: if (bit_end) begin
          state   <= STOP;
          bit_idx <= '0;
          tx      <= 1'b1;
        end
        STOP: if (bit_end) begin
          if (launch) begin
            state   <= START;
            shifter <= rdata;
            tx      <= 1'b0;
          end else if (stop_done) begin
            state <= IDLE;
          end else begin
            bit_idx <= next_idx;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_uart_host_tx.sv
// Bench for uart_host_tx: directed stimulus with a serial-decoding scoreboard
// per instance covering parity modes, stop-bit counts and a fast random run.
`timescale 1ns/1ps
module tb_uart_host_tx;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic [4:0] valid = '0;
  logic [7:0] din [5];
  logic [4:0] rdys, txs, busys;
  logic [4:0] cnt [5];

  int checks = 0;
  int errors = 0;
  int cyc = 0;
  int acc_cyc = 0;
  logic [7:0] expq [5][$];

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  uart_host_tx #(.CLK_FREQ(100_000_000), .BAUD_RATE(1_000_000), .FIFO_DEPTH_LOG2(4),
                 .PARITY(0), .STOP_BITS(1)) u0 (
    .clk(clk), .rst(rst), .in_valid(valid[0]), .in_data(din[0]), .in_ready(rdys[0]),
    .tx(txs[0]), .busy(busys[0]), .fifo_count(cnt[0]));
  uart_host_tx #(.CLK_FREQ(100_000_000), .BAUD_RATE(1_000_000), .FIFO_DEPTH_LOG2(4),
                 .PARITY(1), .STOP_BITS(1)) u1 (
    .clk(clk), .rst(rst), .in_valid(valid[1]), .in_data(din[1]), .in_ready(rdys[1]),
    .tx(txs[1]), .busy(busys[1]), .fifo_count(cnt[1]));
  uart_host_tx #(.CLK_FREQ(100_000_000), .BAUD_RATE(1_000_000), .FIFO_DEPTH_LOG2(4),
                 .PARITY(2), .STOP_BITS(1)) u2 (
    .clk(clk), .rst(rst), .in_valid(valid[2]), .in_data(din[2]), .in_ready(rdys[2]),
    .tx(txs[2]), .busy(busys[2]), .fifo_count(cnt[2]));
  uart_host_tx #(.CLK_FREQ(100_000_000), .BAUD_RATE(1_000_000), .FIFO_DEPTH_LOG2(4),
                 .PARITY(0), .STOP_BITS(2)) u3 (
    .clk(clk), .rst(rst), .in_valid(valid[3]), .in_data(din[3]), .in_ready(rdys[3]),
    .tx(txs[3]), .busy(busys[3]), .fifo_count(cnt[3]));
  uart_host_tx #(.CLK_FREQ(100_000_000), .BAUD_RATE(25_000_000), .FIFO_DEPTH_LOG2(4),
                 .PARITY(1), .STOP_BITS(2)) u4 (
    .clk(clk), .rst(rst), .in_valid(valid[4]), .in_data(din[4]), .in_ready(rdys[4]),
    .tx(txs[4]), .busy(busys[4]), .fifo_count(cnt[4]));

  function automatic void check(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s actual=%0d required=%0d", name, act, req);
    end
  endfunction

  // Called just after a rising edge; returns just after the accepting edge.
  task automatic send(input int id, input logic [7:0] b);
    int n = 0;
    valid[id] = 1'b1;
    din[id]   = b;
    while (!rdys[id] && n < 5000) begin
      @(posedge clk); #1; n++;
    end
    check($sformatf("accept_timeout%0d", id), 32'(n < 5000), 1);
    @(posedge clk); #1;
    valid[id] = 1'b0;
    acc_cyc = cyc;
    expq[id].push_back(b);
  endtask

  task automatic wait_idle(input int id, input int limit);
    int n = 0;
    while (busys[id] && n < limit) begin
      @(posedge clk); #1; n++;
    end
    check($sformatf("idle_timeout%0d", id), 32'(n < limit), 1);
  endtask

  // Single byte from idle: latency, busy span and queue count.
  task automatic single(input int id, input logic [7:0] b, input int flen);
    send(id, b);
    check("busy_on_accept", busys[id], 1);
    check("tx_idle_at_accept", txs[id], 1);
    @(posedge clk); #1;
    check("tx_idle_accept_plus1", txs[id], 1);
    @(posedge clk); #1;
    check("tx_start_accept_plus2", txs[id], 0);
    check("count_after_pop", cnt[id], 0);
    repeat (flen - 1) @(posedge clk);
    #1;
    check("busy_last_stop_cycle", busys[id], 1);
    @(posedge clk); #1;
    check("busy_after_frame", busys[id], 0);
  endtask

  // Serial decoder: checks every cycle of each frame against the ideal waveform.
  task automatic rx_mon(input int id, input int cpb, input int par, input int stp);
    logic [7:0]  exp_b;
    logic [7:0]  got;
    logic [11:0] wave;
    int nb, bad;
    bit quit;
    forever begin
      @(negedge clk);
      quit = 0;
      while (!rst && txs[id] === 1'b0 && !quit) begin
        if (expq[id].size() == 0) begin
          check($sformatf("unexpected_start%0d", id), 1, 0);
          exp_b = 8'h00;
        end else begin
          exp_b = expq[id].pop_front();
        end
        wave = '0;
        for (int j = 0; j < 8; j++) wave[1 + j] = exp_b[j];
        nb = 9;
        if (par != 0) begin
          wave[nb] = (par == 1) ? ^exp_b : ~^exp_b;
          nb++;
        end
        for (int s = 0; s < stp; s++) begin
          wave[nb] = 1'b1;
          nb++;
        end
        bad = 0;
        got = '0;
        for (int j = 0; j < nb && !quit; j++) begin
          for (int c = 0; c < cpb; c++) begin
            if (j != 0 || c != 0) begin
              @(negedge clk);
              if (rst) begin quit = 1; break; end
            end
            if (txs[id] !== wave[j]) bad++;
            if (j >= 1 && j <= 8 && c == cpb / 2) got[j - 1] = txs[id];
          end
        end
        if (!quit) begin
          check($sformatf("rx_byte%0d", id), got, exp_b);
          check($sformatf("rx_shape%0d", id), bad, 0);
          if (expq[id].size() != 0) begin
            @(negedge clk);
            if (!rst) check($sformatf("no_gap%0d", id), txs[id], 0);
          end else begin
            quit = 1;
          end
        end
      end
      if (rst) expq[id].delete();
    end
  endtask

  initial begin
    fork
      rx_mon(0, 100, 0, 1);
      rx_mon(1, 100, 1, 1);
      rx_mon(2, 100, 2, 1);
      rx_mon(3, 100, 0, 2);
      rx_mon(4, 4, 1, 2);
    join_none
  end

  initial begin
    int stall, c0, c17, gap;
    for (int i = 0; i < 5; i++) din[i] = '0;
    repeat (3) @(posedge clk);
    #1;
    check("reset_tx", txs[0], 1);
    check("reset_busy", busys[0], 0);
    check("reset_count", cnt[0], 0);
    check("reset_ready", rdys[0], 1);
    rst = 1'b0;
    @(posedge clk); #1;

    // single frames: plain, even/odd parity
    single(0, 8'h55, 1000);
    single(1, 8'h07, 1100);
    single(2, 8'h07, 1100);

    // 20 bytes back-to-back: 16 in FIFO plus 1 in the shifter before stall
    stall = -1; c0 = 0; c17 = 0;
    for (int i = 0; i < 20; i++) begin
      if (stall < 0 && !rdys[0]) begin
        stall = i;
        check("count_full", cnt[0], 16);
      end
      send(0, 8'(i));
      if (i == 0)  c0 = acc_cyc;
      if (i == 17) c17 = acc_cyc;
    end
    check("accepted_before_stall", stall, 17);
    check("ready_return_gap", c17 - c0, 1003);
    wait_idle(0, 30000);

    // two stop bits, back-to-back
    send(3, 8'hA0);
    send(3, 8'hA1);
    wait_idle(3, 5000);

    // reset at cycle 350 of a frame with 3 bytes queued
    send(0, 8'h11);
    send(0, 8'h12);
    send(0, 8'h13);
    send(0, 8'h14);
    check("count_before_reset", cnt[0], 3);
    repeat (348) @(posedge clk);
    #1;
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    check("rst_mid_tx", txs[0], 1);
    check("rst_mid_count", cnt[0], 0);
    check("rst_mid_busy", busys[0], 0);
    check("rst_mid_ready", rdys[0], 1);
    single(0, 8'h3C, 1000);

    // fast instance: random bytes with random source gaps
    for (int i = 0; i < 300; i++) begin
      send(4, 8'($urandom_range(0, 255)));
      gap = $urandom_range(0, 60);
      repeat (gap) begin
        @(posedge clk); #1;
      end
    end
    wait_idle(4, 20000);
    repeat (10) @(posedge clk);
    #1;
    for (int i = 0; i < 5; i++) check($sformatf("leftover%0d", i), expq[i].size(), 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
